uart_tx_arbiter: RTL

- Shares one UART transmitter between two requesters (for example, the pipeline debug dump and the register-file dump).
- Each requester presents a parameterised multi-byte word. The block picks a requester with round-robin arbitration, latches its word, and sends the word to the transmitter one byte at a time, most-significant byte first.
- Byte transfers use the transmitter's tx_start / tx_done_tick handshake.
- Sits between the requesters and the transmitter. Shares clk/rst with the transmitter.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester words, ack/busy and transmitter byte handshake bundle
interface uart_tx_arbiter_if #(
    parameter int NBYTES = 4
);
    localparam int W = 8 * NBYTES;

    logic [1:0]   req;
    logic [W-1:0] data0;
    logic [W-1:0] data1;
    logic [1:0]   ack;
    logic         busy;
    logic [7:0]   tx_din;
    logic         tx_start;
    logic         tx_done_tick;

    modport slave (
        input  req, data0, data1, tx_done_tick,
        output ack, busy, tx_din, tx_start
    );

    modport master (
        output req, data0, data1, tx_done_tick,
        input  ack, busy, tx_din, tx_start
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin share of one UART transmitter, words sent MSB byte first
// Optional CR/LF suffix after each word: define UART_TX_ARBITER_CRLF_EN.
module uart_tx_arbiter #(
    parameter int NBYTES = 4
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  bus
);
    localparam int W = 8 * NBYTES;
    localparam logic [2:0] LAST = 3'(NBYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_DONE
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] shift_q, shift_d;
    logic [2:0]   byte_cnt_q, byte_cnt_d;
    logic         grant_q, grant_d;
    logic         last_grant_q, last_grant_d;
    logic [1:0]   ack_q, ack_d;
    logic         busy_q, busy_d;
    logic [7:0]   tx_din_q, tx_din_d;
    logic         tx_start_q, tx_start_d;
    logic         pick;
    logic         word_end;
`ifdef UART_TX_ARBITER_CRLF_EN
    logic [1:0]   sfx_cnt_q, sfx_cnt_d;
`endif

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        byte_cnt_d   = byte_cnt_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        ack_d        = 2'b00;
        busy_d       = busy_q;
        tx_din_d     = tx_din_q;
        tx_start_d   = 1'b0;
        pick         = 1'b0;
        word_end     = 1'b0;
`ifdef UART_TX_ARBITER_CRLF_EN
        sfx_cnt_d    = sfx_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    // Prefer whoever did not win last time; otherwise the lone requester.
                    if (bus.req[~last_grant_q]) pick = ~last_grant_q;
                    else                        pick = bus.req[1];
                    grant_d    = pick;
                    shift_d    = pick ? bus.data1 : bus.data0;
                    byte_cnt_d = 3'd0;
`ifdef UART_TX_ARBITER_CRLF_EN
                    sfx_cnt_d  = 2'd0;
`endif
                    tx_din_d   = shift_d[W-1 -: 8];
                    tx_start_d = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.tx_done_tick) begin
                    if (byte_cnt_q != LAST) begin
                        shift_d    = shift_q << 8;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        tx_din_d   = shift_d[W-1 -: 8];
                        tx_start_d = 1'b1;
                        state_d    = S_SEND;
                    end else begin
`ifdef UART_TX_ARBITER_CRLF_EN
                        if (sfx_cnt_q != 2'd2) begin
                            sfx_cnt_d  = sfx_cnt_q + 2'd1;
                            tx_din_d   = (sfx_cnt_q == 2'd0) ? 8'h0D : 8'h0A;
                            tx_start_d = 1'b1;
                            state_d    = S_SEND;
                        end else begin
                            word_end = 1'b1;
                        end
`else
                        word_end = 1'b1;
`endif
                    end
                end
            end
            S_DONE: begin
                last_grant_d = grant_q;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (word_end) begin
            ack_d   = grant_q ? 2'b10 : 2'b01;
            state_d = S_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            shift_q      <= '0;
            byte_cnt_q   <= 3'd0;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            ack_q        <= 2'b00;
            busy_q       <= 1'b0;
            tx_din_q     <= 8'h00;
            tx_start_q   <= 1'b0;
`ifdef UART_TX_ARBITER_CRLF_EN
            sfx_cnt_q    <= 2'd0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            byte_cnt_q   <= byte_cnt_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            ack_q        <= ack_d;
            busy_q       <= busy_d;
            tx_din_q     <= tx_din_d;
            tx_start_q   <= tx_start_d;
`ifdef UART_TX_ARBITER_CRLF_EN
            sfx_cnt_q    <= sfx_cnt_d;
`endif
        end
    end

    assign bus.ack      = ack_q;
    assign bus.busy     = busy_q;
    assign bus.tx_din   = tx_din_q;
    assign bus.tx_start = tx_start_q;
endmodule
